result_bcd_conv: RTL

Sequential binary-to-BCD converter that sits directly downstream of the calculator ALU. It captures the ALU's 17-bit unsigned magnitude result and sign flag on a start pulse, then converts the magnitude to six packed BCD digits with an iterative shift-add-3 (double-dabble) engine. It presents the digits and sign to the display driver with a ready/done handshake.

---
 rtl/result_bcd_conv_if.sv | 25 ++
 rtl/result_bcd_conv.sv | 120 ++++++++++++
 2 files changed

// File: rtl/result_bcd_conv_if.sv
// Handshake and data bundle between the BCD converter and its neighbours.
// The master side is the ALU/display controller, the slave side is the converter.
interface result_bcd_conv_if #(
  parameter int IN_W = 17,
  parameter int NDIG = 6
);
  logic                start;
  logic [IN_W-1:0]     number_in;
  logic                sign_in;
  logic                ready;
  logic                busy;
  logic                done;
  logic [4*NDIG-1:0]   bcd_out;
  logic                sign_out;

  modport master (
    output start, number_in, sign_in,
    input  ready, busy, done, bcd_out, sign_out
  );

  modport slave (
    input  start, number_in, sign_in,
    output ready, busy, done, bcd_out, sign_out
  );
endinterface

// File: rtl/result_bcd_conv.sv
// Iterative double-dabble binary-to-BCD converter for the ALU result.
// Define RESULT_BCD_LZB_EN to blank leading zero digits with 4'hF.
module result_bcd_conv #(
  parameter int IN_W = 17,
  parameter int NDIG = 6
) (
  input logic              clk,
  input logic              clear,
  result_bcd_conv_if.slave bus
);

  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [IN_W-1:0]   bin;
  logic [BW-1:0]     scr;
  logic [BW-1:0]     adj;
  logic [BW+IN_W-1:0] sh;
  logic [CW-1:0]     cnt;
  logic              sign;
  logic [BW-1:0]     bcd;
  logic              sign_q;
  logic              done_q;

`ifdef RESULT_BCD_LZB_EN
  // Digit 0 stays visible so a zero result still shows "0".
  function automatic logic [BW-1:0] fmt(input logic [BW-1:0] v);
    logic lead;
    fmt  = v;
    lead = 1'b1;
    for (int i = NDIG - 1; i > 0; i--) begin
      if (lead && v[4*i +: 4] == 4'd0)
        fmt[4*i +: 4] = 4'hF;
      else
        lead = 1'b0;
    end
  endfunction
`else
  function automatic logic [BW-1:0] fmt(input logic [BW-1:0] v);
    fmt = v;
  endfunction
`endif

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.start) state_n = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state == IDLE);
    bus.busy  = (state != IDLE);
  end

  always_comb begin
    adj = scr;
    for (int i = 0; i < NDIG; i++) begin
      if (scr[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
    end
    sh = {adj, bin} << 1;
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      bin    <= '0;
      scr    <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
      bcd    <= '0;
      sign_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            bin  <= bus.number_in;
            sign <= bus.sign_in;
            scr  <= '0;
            cnt  <= CW'(IN_W);
          end
        end
        SHIFT: begin
          {scr, bin} <= sh;
          cnt        <= cnt - CW'(1);
        end
        DONE: begin
          // Raw scratch is zero only for a zero magnitude: no negative zero.
          bcd    <= fmt(scr);
          sign_q <= sign & (|scr);
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.bcd_out  = bcd;
  assign bus.sign_out = sign_q;
  assign bus.done     = done_q;

endmodule
